odometer_ro_meas_core: RTL and testbench
========================================

# odometer_ro_meas_core

Ring-oscillator measurement core of the silicon odometer, sitting directly downstream of the odometer APB slave register file. It consumes the start/abort/window-length controls that software writes over APB_02. Over a programmed window of pclk_02 cycles, it counts rising edges from a reference oscillator and a stressed (aging) oscillator. It returns both counts, their signed difference and a saturation flag for the register file to expose on PRDATA.

## Interface
- CNT_WIDTH, 16, width of each edge counter and result register
- WIN_WIDTH, 16, width of the window-length field (window in pclk_02 cycles)
- SYNC_STAGES, 2, flip-flop stages in each oscillator synchronizer (minimum 2)

Ports:
- pclk_02  in  1  APB_02 clock; the only clock
- preset_02  in  1  asynchronous, active-high reset
- start_i  in  1  single-cycle start request from the register file
- abort_i  in  1  single-cycle abort request
- win_len_i  in  WIN_WIDTH  measurement window length in cycles; sampled on an accepted start
- ro_ref_i  in  1  divided reference-oscillator output, asynchronous to pclk_02
- ro_str_i  in  1  divided stressed-oscillator output, asynchronous to pclk_02
- busy_o  out  1  measurement in progress
- done_o  out  1  one-cycle pulse; results updated
- ref_cnt_o  out  CNT_WIDTH  reference edge count of the last completed measurement
- str_cnt_o  out  CNT_WIDTH  stressed edge count of the last completed measurement
- delta_o  out  CNT_WIDTH+1  signed two's-complement difference, ref_cnt − str_cnt
- sat_o  out  1  a counter saturated during the last completed measurement

## Operation
- Reset: all outputs 0, state IDLE, synchronizers and edge-detect registers 0.
- Each oscillator input passes through a SYNC_STAGES-deep synchronizer and then a rising-edge detector (sync & ~sync_d).
  - The synchronizers and edge detectors run in every state, so no stale edge is counted after IDLE.
- States: IDLE, ARM, COUNT.
  - IDLE: start_i=1, abort_i=0 and win_len_i≠0 → latch win_len_i into the window counter and go to ARM.
    - A start with win_len_i=0 is ignored.
    - A start with abort_i=1 in the same cycle is ignored.
    - abort_i alone in IDLE has no effect.
  - ARM (1 cycle): clear the internal ref/str counters and the internal saturation flag, then go to COUNT.
    - Edges detected during ARM are not counted.
  - COUNT: each cycle, decrement the window counter.
    - Each detected edge increments its own counter, saturating at 2^CNT_WIDTH−1.
    - An increment attempted at all-ones sets the internal saturation flag.
    - Both oscillators may count in the same cycle.
    - When the window counter is 1, this is the last counted cycle: go to IDLE, load the result registers and pulse done_o.
- Result load:
  - ref_cnt_o and str_cnt_o take the final counts, including any edge in the last COUNT cycle.
  - delta_o is the zero-extended ref minus the zero-extended str, at width CNT_WIDTH+1.
  - sat_o takes the internal saturation flag.
- Results hold until the next completed measurement. They are never cleared by start or abort, only by reset.
- abort_i in ARM or COUNT: go to IDLE next cycle, no done_o, result registers unchanged.
- start_i while busy is ignored. A new start is accepted in the cycle done_o is high, because the state is already IDLE.
- Reset mid-measurement: immediate return to IDLE with all outputs 0.

## Timing
- busy_o is registered and equals state≠IDLE.
- For a start accepted at edge E0 with window N:
  - busy_o rises after E0.
  - ARM occupies cycle E0→E0+1.
  - COUNT occupies N cycles.
  - done_o and busy_o=0 appear together after edge E0+N+1.
  - Result outputs are valid in that same cycle.
- busy_o is high for exactly N+1 cycles.
- done_o is exactly one cycle wide.
- Oscillator edge-to-count latency is SYNC_STAGES+1 cycles.
  - Edges later than the last COUNT cycle minus that latency are lost. This is acceptable and documented for software.
- The oscillator inputs must be divided so each high and low phase lasts at least 2 pclk_02 periods. Faster inputs undercount by design.

## Test plan
- Basic window: start with win_len_i=100, ro_ref toggling every 4 cycles, ro_str every 5 cycles (edges spaced 8 and 10 cycles) → busy_o for 101 cycles, one done_o pulse, ref_cnt_o≈12–13, str_cnt_o≈10, delta_o = ref − str, sat_o=0.
- Negative delta and width: CNT_WIDTH=4, win=40, ref edge every 8 cycles and str edge every 4 cycles → ref=5, str=10, delta_o=5'b11011 (−5), sat_o=0.
- Saturation: CNT_WIDTH=4, win=200, str edge every 6 cycles → str_cnt_o=15, sat_o=1, ref unaffected.
- Abort: start with win=50, abort_i at cycle 20 → busy_o low the next cycle, no done_o, results equal the previous measurement's values.
- Ignored requests:
  - win_len_i=0 → busy_o stays 0.
  - start_i pulsed while busy → no effect on done timing.
  - start_i and abort_i together in IDLE → no start.
  - start_i in the done_o cycle → accepted, busy_o high the next cycle.
- Reset mid-COUNT: assert preset_02 asynchronously → all outputs 0 immediately. After release, a win=10 measurement completes normally in 11 busy cycles.

Source files
------------

// File: rtl/odometer_ro_meas_core_if.sv
// Control and result bundle between the odometer register file and the
// ring-oscillator measurement core.
interface odometer_ro_meas_core_if #(
    parameter int CNT_WIDTH = 16,
    parameter int WIN_WIDTH = 16
);
    logic                        start_i;
    logic                        abort_i;
    logic [WIN_WIDTH-1:0]        win_len_i;
    logic                        ro_ref_i;
    logic                        ro_str_i;
    logic                        busy_o;
    logic                        done_o;
    logic [CNT_WIDTH-1:0]        ref_cnt_o;
    logic [CNT_WIDTH-1:0]        str_cnt_o;
    logic signed [CNT_WIDTH:0]   delta_o;
    logic                        sat_o;

    modport master (
        output start_i, abort_i, win_len_i, ro_ref_i, ro_str_i,
        input  busy_o, done_o, ref_cnt_o, str_cnt_o, delta_o, sat_o
    );

    modport slave (
        input  start_i, abort_i, win_len_i, ro_ref_i, ro_str_i,
        output busy_o, done_o, ref_cnt_o, str_cnt_o, delta_o, sat_o
    );
endinterface

// File: rtl/odometer_ro_meas_core.sv
// Counts reference and stressed ring-oscillator edges over a programmed window
// of pclk_02 cycles and publishes both counts, their difference and a saturation flag.
module odometer_ro_meas_core #(
    parameter int CNT_WIDTH   = 16,
    parameter int WIN_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    pclk_02,
    input  logic                    preset_02,
    odometer_ro_meas_core_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ARM, COUNT} state_t;

    state_t                    state_q, state_d;
    logic [WIN_WIDTH-1:0]      win_q, win_d;
    logic [CNT_WIDTH-1:0]      ref_q, ref_d, str_q, str_d;
    logic                      sat_q, sat_d;
    logic                      busy_q, busy_d, done_q, done_d;
    logic [CNT_WIDTH-1:0]      ref_res_q, ref_res_d, str_res_q, str_res_d;
    logic signed [CNT_WIDTH:0] delta_q, delta_d;
    logic                      sat_res_q, sat_res_d;

    logic [SYNC_STAGES-1:0]    ref_sync_q, str_sync_q;
    logic                      ref_dly_q, str_dly_q;
    logic                      ref_edge, str_edge;
    logic [CNT_WIDTH:0]        ref_inc, str_inc;

    // Returns {overflow_attempt, next_count}; the count sticks at all-ones.
    function automatic logic [CNT_WIDTH:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic inc);
        if (!inc)
            return {1'b0, cnt};
        if (&cnt)
            return {1'b1, cnt};
        return {1'b0, cnt + CNT_WIDTH'(1)};
    endfunction

    function automatic logic signed [CNT_WIDTH:0] diff(input logic [CNT_WIDTH-1:0] a,
                                                       input logic [CNT_WIDTH-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    assign ref_edge = ref_sync_q[SYNC_STAGES-1] & ~ref_dly_q;
    assign str_edge = str_sync_q[SYNC_STAGES-1] & ~str_dly_q;

    // Synchronizers and edge detectors free-run so no stale edge survives IDLE.
    always_ff @(posedge pclk_02 or posedge preset_02) begin
        if (preset_02) begin
            ref_sync_q <= '0;
            str_sync_q <= '0;
            ref_dly_q  <= 1'b0;
            str_dly_q  <= 1'b0;
        end else begin
            ref_sync_q <= {ref_sync_q[SYNC_STAGES-2:0], bus.ro_ref_i};
            str_sync_q <= {str_sync_q[SYNC_STAGES-2:0], bus.ro_str_i};
            ref_dly_q  <= ref_sync_q[SYNC_STAGES-1];
            str_dly_q  <= str_sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge pclk_02 or posedge preset_02) begin
        if (preset_02) begin
            state_q   <= IDLE;
            win_q     <= '0;
            ref_q     <= '0;
            str_q     <= '0;
            sat_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ref_res_q <= '0;
            str_res_q <= '0;
            delta_q   <= '0;
            sat_res_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            ref_q     <= ref_d;
            str_q     <= str_d;
            sat_q     <= sat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ref_res_q <= ref_res_d;
            str_res_q <= str_res_d;
            delta_q   <= delta_d;
            sat_res_q <= sat_res_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        ref_d     = ref_q;
        str_d     = str_q;
        sat_d     = sat_q;
        done_d    = 1'b0;
        ref_res_d = ref_res_q;
        str_res_d = str_res_q;
        delta_d   = delta_q;
        sat_res_d = sat_res_q;
        ref_inc   = sat_inc(ref_q, ref_edge);
        str_inc   = sat_inc(str_q, str_edge);

        case (state_q)
            IDLE: begin
                if (bus.start_i && !bus.abort_i && (bus.win_len_i != '0)) begin
                    win_d   = bus.win_len_i;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else begin
                    ref_d   = '0;
                    str_d   = '0;
                    sat_d   = 1'b0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else begin
                    ref_d = ref_inc[CNT_WIDTH-1:0];
                    str_d = str_inc[CNT_WIDTH-1:0];
                    sat_d = sat_q | ref_inc[CNT_WIDTH] | str_inc[CNT_WIDTH];
                    win_d = win_q - WIN_WIDTH'(1);
                    // Last counted cycle: publish counts including this cycle's edges.
                    if (win_q == WIN_WIDTH'(1)) begin
                        state_d   = IDLE;
                        done_d    = 1'b1;
                        ref_res_d = ref_d;
                        str_res_d = str_d;
                        delta_d   = diff(ref_d, str_d);
                        sat_res_d = sat_d;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.ref_cnt_o = ref_res_q;
    assign bus.str_cnt_o = str_res_q;
    assign bus.delta_o   = delta_q;
    assign bus.sat_o     = sat_res_q;

endmodule

// File: tb/tb_odometer_ro_meas_core.sv
// Bench for odometer_ro_meas_core: table of measurement windows plus hand-written
// abort, ignored-request, back-to-back and reset sequences, checked via a scoreboard.
module tb_odometer_ro_meas_core;

    localparam int CW   = 4;
    localparam int WW   = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    odometer_ro_meas_core_if #(.CNT_WIDTH(CW), .WIN_WIDTH(WW)) bus();

    odometer_ro_meas_core #(.CNT_WIDTH(CW), .WIN_WIDTH(WW), .SYNC_STAGES(2)) u_dut (
        .pclk_02   (clk),
        .preset_02 (rst),
        .bus       (bus)
    );

    typedef struct {
        int            done_cyc;
        logic [CW-1:0] r;
        logic [CW-1:0] s;
        logic [CW:0]   d;
        logic          sat;
    } exp_t;

    typedef struct {
        int            win;
        int            rh;
        int            sh;
        int            poke;
        logic [CW-1:0] r;
        logic [CW-1:0] s;
        logic [CW:0]   d;
        logic          sat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int osc_o = 0, ref_h = 0, str_h = 0;
    int busy_run = 0, busy_len = 0;
    logic [CW-1:0] last_r = '0, last_s = '0;
    logic [CW:0]   last_d = '0;
    logic          last_sat = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Oscillator level driven after edge t: low until osc_o, then half-period h.
    function automatic logic osc(input int t, input int h);
        if (h == 0 || t < osc_o) return 1'b0;
        return (((t - osc_o) / h) % 2) == 1;
    endfunction

    // A rise driven after edge t is counted iff t lies in [E0-1, E0+N-2].
    function automatic int rises(input int e0, input int n, input int h);
        int c = 0;
        for (int t = e0 - 1; t <= e0 + n - 2; t++)
            if (osc(t, h) && !osc(t - 1, h)) c++;
        return c;
    endfunction

    task automatic set_osc(input int rh, input int sh);
        ref_h = rh;
        str_h = sh;
        osc_o = cyc + 1;
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (bus.busy_o) busy_run++;
        else if (busy_run > 0) begin
            busy_len = busy_run;
            busy_run = 0;
        end
        if (bus.done_o) begin
            if (sb.size() == 0) begin
                check("unexpected_done", bus.done_o, 0);
            end else begin
                e = sb.pop_front();
                check("done_cycle", cyc, e.done_cyc);
                check("ref_cnt", bus.ref_cnt_o, e.r);
                check("str_cnt", bus.str_cnt_o, e.s);
                check("delta", $unsigned(bus.delta_o), e.d);
                check("sat", bus.sat_o, e.sat);
                last_r = e.r; last_s = e.s; last_d = e.d; last_sat = e.sat;
            end
        end
        bus.ro_ref_i = osc(cyc, ref_h);
        bus.ro_str_i = osc(cyc, str_h);
    endtask

    task automatic start_exp(input int win, input logic [CW-1:0] r, input logic [CW-1:0] s,
                             input logic [CW:0] d, input logic sat);
        exp_t e;
        e.done_cyc = cyc + 1 + win + 1;
        e.r = r; e.s = s; e.d = d; e.sat = sat;
        sb.push_back(e);
        bus.win_len_i = WW'(win);
        bus.start_i   = 1'b1;
        step();
        bus.start_i   = 1'b0;
    endtask

    task automatic start_auto(input int win);
        int cr, cs, rr, ss, dd;
        cr = rises(cyc + 1, win, ref_h);
        cs = rises(cyc + 1, win, str_h);
        rr = (cr > CMAX) ? CMAX : cr;
        ss = (cs > CMAX) ? CMAX : cs;
        dd = rr - ss;
        start_exp(win, rr[CW-1:0], ss[CW-1:0], dd[CW:0], (cr > CMAX) || (cs > CMAX));
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (!bus.done_o && k < bound) begin
            step();
            k++;
        end
        check("done_seen", bus.done_o, 1);
    endtask

    task automatic finish_meas(input int win);
        check("busy_at_done", bus.busy_o, 0);
        step();
        check("done_width", bus.done_o, 0);
        check("busy_len", busy_len, win + 1);
    endtask

    task automatic run_meas(input vec_t v);
        set_osc(v.rh, v.sh);
        step();
        step();
        start_exp(v.win, v.r, v.s, v.d, v.sat);
        check("busy_after_start", bus.busy_o, 1);
        if (v.poke > 0) begin
            repeat (v.poke) step();
            bus.win_len_i = WW'(3);
            bus.start_i   = 1'b1;
            step();
            bus.start_i   = 1'b0;
        end
        wait_done(v.win + 5);
        finish_meas(v.win);
    endtask

    task automatic check_results_held(input string tag);
        check({tag, "_ref"}, bus.ref_cnt_o, last_r);
        check({tag, "_str"}, bus.str_cnt_o, last_s);
        check({tag, "_delta"}, $unsigned(bus.delta_o), last_d);
        check({tag, "_sat"}, bus.sat_o, last_sat);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, bus.busy_o, 0);
        check({tag, "_done"}, bus.done_o, 0);
        check({tag, "_ref"}, bus.ref_cnt_o, 0);
        check({tag, "_str"}, bus.str_cnt_o, 0);
        check({tag, "_delta"}, $unsigned(bus.delta_o), 0);
        check({tag, "_sat"}, bus.sat_o, 0);
    endtask

    initial begin
        int nd;
        vecs[0] = '{win:100, rh:4,  sh:5, poke:30, r:4'd13, s:4'd10, d:5'd3,      sat:1'b0};
        vecs[1] = '{win:40,  rh:4,  sh:2, poke:0,  r:4'd5,  s:4'd10, d:5'b11011,  sat:1'b0};
        vecs[2] = '{win:200, rh:10, sh:3, poke:0,  r:4'd10, s:4'd15, d:5'b11011,  sat:1'b1};
        vecs[3] = '{win:1,   rh:2,  sh:2, poke:0,  r:4'd0,  s:4'd0,  d:5'd0,      sat:1'b0};
        vecs[4] = '{win:16,  rh:2,  sh:8, poke:0,  r:4'd4,  s:4'd1,  d:5'd3,      sat:1'b0};
        vecs[5] = '{win:60,  rh:2,  sh:0, poke:0,  r:4'd15, s:4'd0,  d:5'd15,     sat:1'b0};
        vecs[6] = '{win:64,  rh:2,  sh:2, poke:0,  r:4'd15, s:4'd15, d:5'd0,      sat:1'b1};

        rst = 1'b1;
        bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.win_len_i = '0;
        bus.ro_ref_i = 1'b0; bus.ro_str_i = 1'b0;
        step();
        check_all_zero("reset");
        step();
        rst = 1'b0;
        step();
        step();

        for (int i = 0; i < 7; i++) run_meas(vecs[i]);

        // Abort in COUNT, twenty cycles after the start edge
        set_osc(4, 5);
        step(); step();
        bus.win_len_i = WW'(50); bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        check("abort_busy_pre", bus.busy_o, 1);
        repeat (19) step();
        bus.abort_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
        check("abort_busy", bus.busy_o, 0);
        // Abort during ARM
        bus.win_len_i = WW'(20); bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        bus.abort_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
        check("abort_arm_busy", bus.busy_o, 0);
        nd = 0;
        repeat (60) begin
            step();
            if (bus.done_o) nd++;
        end
        check("abort_no_done", nd, 0);
        check_results_held("abort_hold");

        // Zero-length window and start+abort together are ignored
        bus.win_len_i = '0; bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        check("win0_busy", bus.busy_o, 0);
        step();
        check("win0_busy2", bus.busy_o, 0);
        bus.win_len_i = WW'(10); bus.start_i = 1'b1; bus.abort_i = 1'b1;
        step();
        bus.start_i = 1'b0; bus.abort_i = 1'b0;
        check("start_abort_busy", bus.busy_o, 0);
        step();
        check("start_abort_busy2", bus.busy_o, 0);
        check_results_held("ignored_hold");

        // Back-to-back: new start in the done cycle
        set_osc(2, 7);
        step(); step();
        start_auto(10);
        wait_done(20);
        start_auto(12);
        check("chain_busy", bus.busy_o, 1);
        wait_done(20);
        finish_meas(12);

        // Asynchronous reset mid-COUNT, then a normal window
        set_osc(4, 5);
        step(); step();
        bus.win_len_i = WW'(50); bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        repeat (20) step();
        #2 rst = 1'b1;
        #1;
        check_all_zero("midreset");
        step();
        rst = 1'b0;
        set_osc(0, 0);
        repeat (5) step();
        set_osc(3, 4);
        step(); step();
        start_auto(10);
        check("post_reset_busy", bus.busy_o, 1);
        wait_done(20);
        finish_meas(10);

        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
